// File: rtl/modular_inverter.sv
// Fermat modular inverter: c = a^(q-2) mod q via MSB-first square-and-multiply
// over a 3-stage multiply-reduce pipeline. Define INV_ZERO_CHECK_EN for the zero-operand early exit.
module modular_inverter #(
  parameter int unsigned MODULUS = 998244353
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [29:0] a,
  output logic        busy,
  output logic        done,
  output logic [29:0] c,
  output logic        err
);

  localparam logic [29:0] Q     = 30'(MODULUS);
  localparam logic [29:0] Exp   = 30'(MODULUS - 2);
  localparam logic [59:0] QWide = 60'(MODULUS);

  typedef enum logic [1:0] {StIdle, StSqr, StMul, StFin} state_e;

  state_e      state_q, state_d;
  logic [4:0]  bit_q, bit_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [29:0] ar_q, r_q, op1_q, op2_q, c_q;
  logic [59:0] prod_q;
  logic        err_q;

  logic [29:0] a_red;
  logic [29:0] red;
  logic        zero_op;
  logic        op_done;

  // q > 2^29 for a 30-bit prime, so any 30-bit operand is below 2q: one subtract reduces it.
  assign a_red = (a >= Q) ? a - Q : a;
  assign red   = 30'(prod_q % QWide);

`ifdef INV_ZERO_CHECK_EN
  assign zero_op = (a_red == '0);
`else
  assign zero_op = 1'b0;
`endif

  assign op_done = ((state_q == StSqr) || (state_q == StMul)) && (cnt_q == 2'd2);

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          cnt_d   = 2'd0;
          bit_d   = 5'd29;
          state_d = zero_op ? StFin : StSqr;
        end
      end
      StSqr: begin
        if (cnt_q == 2'd2) begin
          cnt_d = 2'd0;
          if (Exp[bit_q]) begin
            state_d = StMul;
          end else if (bit_q == 5'd0) begin
            state_d = StFin;
          end else begin
            bit_d = bit_q - 5'd1;
          end
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      StMul: begin
        if (cnt_q == 2'd2) begin
          cnt_d = 2'd0;
          if (bit_q == 5'd0) begin
            state_d = StFin;
          end else begin
            bit_d   = bit_q - 5'd1;
            state_d = StSqr;
          end
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      bit_q   <= '0;
      cnt_q   <= '0;
      ar_q    <= '0;
      r_q     <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      prod_q  <= '0;
      c_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
      // Pipeline runs freely; only the cnt==2 result is committed to the accumulator.
      op1_q   <= r_q;
      op2_q   <= (state_q == StMul) ? ar_q : r_q;
      prod_q  <= 60'(op1_q) * 60'(op2_q);
      if (state_q == StIdle && start) begin
        r_q  <= 30'd1;
        ar_q <= a_red;
        if (zero_op) begin
          c_q   <= '0;
          err_q <= 1'b1;
        end
      end
      if (op_done) begin
        r_q <= red;
        if (state_d == StFin) begin
          c_q   <= red;
          err_q <= 1'b0;
        end
      end
    end
  end

  assign busy = (state_q != StIdle);
  assign done = (state_q == StFin);
  assign c    = c_q;
  assign err  = err_q;

endmodule

// File: doc/modular_inverter.md
MODULAR_INVERTER -- requirements
Module: modular_inverter

Interface
REQ-001 The block SHALL have one parameter: MODULUS, default 998244353, a 30-bit prime modulus q.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 Ports SHALL be, in order:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request to compute an inverse; sampled on a clk edge.
- a  input  30  operand, sampled on the accepting edge.
- busy  output  1  high while a computation is in progress.
- done  output  1  one-cycle pulse when c is valid.
- c  output  30  modular inverse of a, mod q.
- err  output  1  zero-operand flag, valid with done.

Function
REQ-004 The block SHALL compute c = a^(q-2) mod q (Fermat inversion), so that a*c mod q = 1 for every a != 0 mod q.
REQ-005 On acceptance, the operand SHALL be reduced once: a_r = a mod q. Operands a >= q are legal.
REQ-006 The block SHALL contain one internal multiply-reduce unit with exactly 3 cycles of latency:
- stage 1: register both operands;
- stage 2: register the 60-bit product;
- stage 3: register the product mod q.
REQ-007 The block SHALL have four states: IDLE, SQR, MUL, FIN.
REQ-008 Exponent scan SHALL work as follows:
- E = q-2; bits 29 down to 0 are scanned MSB-first.
- The accumulator r starts at 1 on acceptance.
- Each bit costs one SQR (r = r*r, 3 cycles).
- If the bit is 1, a MUL (r = r*a_r, 3 cycles) follows.
- After bit 0, the state is FIN.
REQ-009 State transitions SHALL be:
- IDLE -> SQR on start.
- SQR -> MUL when the bit is 1, otherwise next SQR or FIN.
- MUL -> next SQR or FIN.
- FIN -> IDLE after one cycle.
REQ-010 Latency SHALL be fixed and independent of a: done rises exactly 3*(30+popcount(q-2))+1 edges after the accepting edge. For the default q this is 175 edges.
REQ-011 start SHALL be accepted only in IDLE. start while busy=1 SHALL be ignored, with no effect on the state or on c.
REQ-012 busy SHALL be 1 from the edge after acceptance through the FIN cycle inclusive, and 0 in IDLE.
REQ-013 done SHALL be high for exactly the FIN cycle. c and err SHALL update in the same cycle and hold until the next FIN.
REQ-014 start asserted in the same cycle that done is high SHALL be ignored. It is accepted on the next cycle, in IDLE.
REQ-015 Continuous start SHALL produce back-to-back computations, each separated by exactly one IDLE cycle.

Reset
REQ-016 rst_n low SHALL immediately force the following, regardless of clk:
- state IDLE;
- busy 0, done 0, err 0;
- c 0;
- pipeline registers and accumulator 0.
REQ-017 Reset asserted mid-computation SHALL abort it without a done pulse. The first start after rst_n deasserts SHALL behave as from power-up.

Configuration
REQ-018 Macro INV_ZERO_CHECK_EN SHALL control zero-operand handling.
- Defined: if a_r == 0, the state goes from IDLE directly to FIN on the edge after acceptance (done after 1 edge), with c = 0 and err = 1. For a_r != 0, err = 0.
- Undefined: a_r == 0 runs the full exponentiation, yielding c = 0 at the REQ-010 latency. err is tied to 0.

Verification
REQ-019 The bench SHALL cover these scenarios, with default MODULUS:
- Inversion and latency: a=2 -> c=499122177, err=0, done exactly 175 edges after acceptance, busy low the cycle after done.
- Boundary operands: a=1 -> c=1; a=998244352 -> c=998244352; a=3 -> c=332748118.
- Operand reduction: a=998244355 (equal to 2 mod q) -> c=499122177.
- Zero operand: a=0 -> with INV_ZERO_CHECK_EN, done 1 edge after acceptance, c=0, err=1; without it, done after 175 edges, c=0, err=0.
- Handshake: start pulsed at cycle 50 of a busy computation -> ignored, and the single result matches the first operand. Start held high -> done pulses every 176 cycles.
- Reset mid-operation: rst_n low at cycle 100 -> busy, done, c are 0 immediately and no done pulse follows. A later start with a=3 -> c=332748118.
